// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
//
// The controller consumes the instruction fields (op, funct) and the ALU
// zero flag, and produces every datapath enable and select plus the debug
// state and the illegal-instruction pulse.
//
// Signal direction:
//   - The master modport is the controller side.
//   - The slave modport is the datapath side.
//
// Timing: there is no handshake on this bus. op, funct and zero are
// treated as level signals that are valid for the whole clock cycle. Every
// output is valid in the cycle in which it is presented.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       alusrca;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst,
           memtoreg, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst,
           memtoreg, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset main controller (Moore FSM) with ALU decoder.
//
// Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq and j.
// addi is supported only when the macro MULTICYCLE_ADDI_EN is defined.
// Without that macro, opcode 001000 is reported as illegal, and state
// encodings 9 and 10 behave as unused.
//
// Ports:
//   clk   - rising-edge clock.
//   reset - synchronous, active-high reset. It loads FETCH, and while it is
//           high it gates pcen, irwrite, memwrite, regwrite and illegal.
//   bus   - multicycle_ctrl_if.master. It carries op, funct and zero in,
//           and all datapath controls, the illegal pulse and the debug
//           state out.
module multicycle_ctrl (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_if.master      bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q;
  state_t     state_d;

  // Raw per-state controls, before reset gating.
  logic       pcwrite;
  logic       branch;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       illegal_s;
  logic       iord_s;
  logic       alusrca_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic [1:0] alusrcb_s;
  logic [1:0] pcsrc_s;
  logic [1:0] aluop;

  logic [2:0] alucontrol_s;
  logic       funct_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // ALU decoder. An unrecognised funct falls back to add (010), and the
  // FSM uses funct_ok to abort the R-type instruction.
  always_comb begin
    alucontrol_s = 3'b010;
    funct_ok     = 1'b1;
    case (bus.funct)
      6'b100000: ;
      6'b100010: ;
      6'b100100: ;
      6'b100101: ;
      6'b101010: ;
      default:   funct_ok = 1'b0;
    endcase
    case (aluop)
      2'b01:   alucontrol_s = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: alucontrol_s = 3'b010;
          6'b100010: alucontrol_s = 3'b110;
          6'b100100: alucontrol_s = 3'b000;
          6'b100101: alucontrol_s = 3'b001;
          6'b101010: alucontrol_s = 3'b111;
          default:   alucontrol_s = 3'b010;
        endcase
      end
      default: alucontrol_s = 3'b010;
    endcase
  end

  // Next-state logic and Moore outputs. illegal_s is the only
  // input-dependent output here.
  always_comb begin
    state_d    = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    iord_s     = 1'b0;
    alusrca_s  = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    alusrcb_s  = 2'b00;
    pcsrc_s    = 2'b00;
    aluop      = 2'b00;
    case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb_s = 2'b01;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrcb_s = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          OP_J:         state_d = JEX;
          default: begin
            // Unsupported opcode: the instruction is dropped, and no write
            // enable has been raised for it.
            illegal_s = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        state_d   = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord_s  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop     = 2'b10;
        if (funct_ok) state_d = RTYPEWB;
        else          illegal_s = 1'b1;
      end
      RTYPEWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca_s = 1'b1;
        aluop     = 2'b01;
        pcsrc_s   = 2'b01;
        branch    = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
      end
`endif
      JEX: begin
        pcsrc_s = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // While reset is high, suppress every enable that could disturb
  // architectural state.
  assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero));
  assign bus.irwrite    = ~reset & irwrite_s;
  assign bus.memwrite   = ~reset & memwrite_s;
  assign bus.regwrite   = ~reset & regwrite_s;
  assign bus.illegal    = ~reset & illegal_s;
  assign bus.iord       = iord_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.alucontrol = alucontrol_s;
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register.
REQ-005 funct  input  6  function field of the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pcen  output  1  PC write enable, equal to pcwrite OR (branch AND zero).
REQ-008 irwrite, memwrite, regwrite  output  1 each  write enables for the instruction register, memory and register file.
REQ-009 iord, alusrca, regdst, memtoreg  output  1 each  datapath multiplexer selects.
REQ-010 alusrcb  output  2  ALU B-input select (00 reg, 01 const 4, 10 signimm, 11 signimm<<2).
REQ-011 pcsrc  output  2  next-PC select (00 ALU result, 01 ALUOut, 10 jump target).
REQ-012 alucontrol  output  3  ALU operation.
REQ-013 illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM; every output except pcen and illegal SHALL depend on the state only.
REQ-016 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
REQ-017 Transitions SHALL be:
- FETCH->DECODE.
- DECODE on op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH.
- MEMADR: op 100011 -> MEMRD, else MEMWR.
- MEMRD->MEMWB.
- RTYPEEX->RTYPEWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX -> FETCH.
- Unused encodings 12-15 -> FETCH.
REQ-018 Per-state asserted outputs SHALL be as below; any output not listed is 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-019 alucontrol SHALL be decoded from the internal aluop: 00 -> 010, 01 -> 110, 10 -> decode funct (100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111).
REQ-020 An unknown funct in RTYPEEX SHALL drive alucontrol=010, pulse illegal, and go to FETCH with no RTYPEWB.
REQ-021 An unknown op in DECODE SHALL pulse illegal in that cycle; no write enable SHALL assert for the instruction.
REQ-022 Cycles per instruction SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-023 A taken beq (zero=1 in BEQEX) SHALL assert pcen in that cycle only; with zero=0, pcen SHALL be 0.

Reset
REQ-024 reset high at a rising edge SHALL load state=FETCH, including when it arrives mid-instruction.
REQ-025 While reset is high, pcen, irwrite, memwrite, regwrite and illegal SHALL be forced to 0.
REQ-026 In the first cycle after reset deasserts, FETCH outputs SHALL apply (pcen=1, irwrite=1).

Configuration
REQ-027 With macro MULTICYCLE_ADDI_EN defined, addi SHALL follow DECODE->ADDIEX->ADDIWB->FETCH.
REQ-028 Without MULTICYCLE_ADDI_EN, op 001000 SHALL be treated as illegal per REQ-021, and encodings 9 and 10 SHALL be treated as unused per REQ-017.

Verification
REQ-029 Reset released, then op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-030 op=000000, funct=101010 -> alucontrol=111 in state 6; regwrite=1, regdst=1 in state 7; then state 0.
REQ-031 op=000100 with zero=1 -> pcen=1 and pcsrc=01 in state 8; repeat with zero=0 -> pcen=0; both return to 0 after 3 cycles.
REQ-032 op=111111 -> illegal=1 in state 1, next state 0, no write enable asserted; op=000000 with funct=000000 -> illegal=1 in state 6, next state 0.
REQ-033 reset asserted during state 3 -> state=0 at the next edge, memwrite and regwrite stay 0.
REQ-034 op=001000 -> with MULTICYCLE_ADDI_EN, states 0,1,9,10,0 with regwrite=1 in state 10; without it, illegal=1 in state 1, then state 0.
